lutnet_neuron_array: RTL and testbench

LUTNET_NEURON_ARRAY -- requirements
Module: lutnet_neuron_array

---
 rtl/lutnet_neuron_array.sv | 110 +++++++++++
 tb/tb_lutnet_neuron_array.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lutnet_neuron_array.sv
// Array of LUT-based neurons: each neuron maps its input slice through a
// writable truth table, behind a two-stage valid/ready pipeline.
module lutnet_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int FAN_IN    = 4,
  parameter int IN_BITS   = 2,
  parameter int OUT_BITS  = 2,
  localparam int AW       = FAN_IN * IN_BITS,
  localparam int NW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_NEURONS*AW-1:0]       s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                          cfg_we,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [AW-1:0]                 cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data
);

  localparam int DEPTH = 1 << AW;

  logic [OUT_BITS-1:0]           tbl_q [N_NEURONS][DEPTH];
  logic                          v1_q, v1_d, v2_q, v2_d;
  logic [N_NEURONS*AW-1:0]       a1_q, a1_d;
  logic [N_NEURONS*OUT_BITS-1:0] y2_q, y2_d, lookup_s;
  logic                          s2_adv_s, s1_adv_s, accept_s;
  logic [31:0]                   cfg_idx_s;

  assign s2_adv_s  = !v2_q || m_ready;
  assign s1_adv_s  = !v1_q || s2_adv_s;
  assign s_ready   = s1_adv_s;
  assign accept_s  = s_valid && s1_adv_s;
  assign m_valid   = v2_q;
  assign m_data    = y2_q;
  assign cfg_idx_s = 32'(cfg_neuron);

  // Table read for every neuron at the S1 address, raw slice as index.
  always_comb begin
    lookup_s = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      lookup_s[n*OUT_BITS +: OUT_BITS] = tbl_q[n][a1_q[n*AW +: AW]];
    end
  end

  // Pipeline next state; an S2 sample stalled by m_ready keeps its captured lookup.
  always_comb begin
    v1_d = v1_q;
    a1_d = a1_q;
    v2_d = v2_q;
    y2_d = y2_q;
    if (s1_adv_s) begin
      v1_d = accept_s;
      if (accept_s) begin
        a1_d = s_data;
      end else begin
        a1_d = a1_q;
      end
    end else begin
      v1_d = v1_q;
    end
    if (s2_adv_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        y2_d = lookup_s;
      end else begin
        y2_d = y2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      v2_q <= 1'b0;
      y2_q <= '0;
    end else begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      v2_q <= v2_d;
      y2_q <= y2_d;
    end
  end

  // Truth tables; out-of-range neuron indices match no table and write nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        for (int e = 0; e < DEPTH; e++) begin
          tbl_q[n][e] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < N_NEURONS; n++) begin
        if (cfg_we && (cfg_idx_s == 32'(n))) begin
          tbl_q[n][cfg_addr] <= cfg_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lutnet_neuron_array.sv
// Randomized bench for lutnet_neuron_array: scoreboard of expected outputs
// computed from a reference copy of the truth tables.
module tb_lutnet_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready, cfg_we;
  logic [31:0] s_data;
  logic [7:0]  m_data;
  logic [1:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_data;

  logic        s_valid3, s_ready3, m_valid3, m_ready3, cfg_we3;
  logic [23:0] s_data3;
  logic [5:0]  m_data3;
  logic [1:0]  cfg_neuron3;
  logic [7:0]  cfg_addr3;
  logic [1:0]  cfg_data3;

  always #5 clk = ~clk;

  lutnet_neuron_array u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  lutnet_neuron_array #(.N_NEURONS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3),
    .cfg_we(cfg_we3), .cfg_neuron(cfg_neuron3), .cfg_addr(cfg_addr3), .cfg_data(cfg_data3)
  );

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } item_t;

  item_t      q[$];
  logic [1:0] mtbl [4][256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         pops     = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] obs_mdata;
  logic       acc;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_lookup(input logic [31:0] sd);
    logic [7:0] r;
    r = 8'h00;
    for (int n = 0; n < 4; n++) begin
      r[n*2 +: 2] = mtbl[n][sd[n*8 +: 8]];
    end
    return r;
  endfunction

  task automatic clear_model();
    q.delete();
    for (int n = 0; n < 4; n++) begin
      for (int e = 0; e < 256; e++) begin
        mtbl[n][e] = 2'b00;
      end
    end
    hold_prev = 1'b0;
  endtask

  // One clock cycle: drive, check against the scoreboard, then update the model at the edge.
  task automatic step(input logic sv, input logic [31:0] sd, input logic mr,
                      input logic we, input logic [1:0] cn, input logic [7:0] ca,
                      input logic [1:0] cd, output logic accepted);
    logic  exp_sr, exp_mv;
    item_t it;
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr;
    cfg_we = we; cfg_neuron = cn; cfg_addr = ca; cfg_data = cd;
    #1;
    exp_sr = (q.size() < 2) || mr;
    exp_mv = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    check_val("s_ready", 32'(s_ready), 32'(exp_sr));
    check_val("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) check_val("m_data", 32'(m_data), 32'(q[0].val));
    if (hold_prev) check_val("m_stable", 32'(m_data), 32'(prev_data));
    obs_mdata = m_data;
    hold_prev = exp_mv && !mr;
    prev_data = m_data;
    accepted  = sv && exp_sr;
    @(posedge clk);
    if (exp_mv && mr) begin
      void'(q.pop_front());
      pops++;
    end
    if (we) mtbl[cn][ca] = cd;
    if (accepted) begin
      it.val = ref_lookup(sd);
      it.cyc = cyc;
      q.push_back(it);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 8'h00, 2'b00, acc);
  endtask

  task automatic sample(input logic [31:0] sd);
    step(1'b1, sd, 1'b1, 1'b0, 2'd0, 8'h00, 2'b00, acc);
  endtask

  // Pulse reset for one cycle with a write attempt that must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0; m_ready = 1'b1;
    cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 8'h00; cfg_data = 2'b11;
    #1;
    check_val("rst_m_valid", 32'(m_valid), 32'h0);
    check_val("rst_m_data", 32'(m_data), 32'h0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [31:0] d27 [8];
    int          sent;

    rst_n = 1'b0;
    s_valid = 1'b0; s_data = 32'h0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = 2'd0; cfg_addr = 8'h00; cfg_data = 2'b00;
    s_valid3 = 1'b0; s_data3 = 24'h0; m_ready3 = 1'b1;
    cfg_we3 = 1'b0; cfg_neuron3 = 2'd0; cfg_addr3 = 8'h00; cfg_data3 = 2'b00;
    clear_model();
    #2;
    check_val("init_m_valid", 32'(m_valid), 32'h0);
    check_val("init_m_data", 32'(m_data), 32'h0);
    do_reset();

    // Zero tables: every output is zero, first valid two cycles after accept.
    sample(32'h00);
    sample(32'h55);
    sample(32'hFF);
    idle(4);

    // Directed neuron 0 and neuron 3 entries.
    step(1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 8'h1B, 2'b11, acc);
    step(1'b0, 32'h0, 1'b1, 1'b1, 2'd3, 8'h1B, 2'b10, acc);
    sample(32'h1B1B1B1B);
    idle(2);
    check_val("tbl_write_out", 32'(obs_mdata), 32'h83);
    idle(1);

    // Random traffic with backpressure, tables static.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           1'b0, 2'd0, 8'h00, 2'b00, acc);
    end
    idle(4);

    // Random traffic with concurrent table writes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 8'($urandom), 2'($urandom), acc);
    end

    // Reset with two samples in flight and non-zero tables.
    step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 8'h00, 2'b00, acc);
    step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 8'h00, 2'b00, acc);
    do_reset();
    for (int i = 0; i < 4; i++) sample($urandom);
    idle(3);
    check_val("post_rst_zero", 32'(obs_mdata), 32'h0);

    // Write racing the S1->S2 lookup of the same entry.
    sample(32'h00000042);
    step(1'b1, 32'h00000042, 1'b1, 1'b1, 2'd0, 8'h42, 2'b01, acc);
    idle(1);
    check_val("race_old", 32'(obs_mdata[1:0]), 32'h0);
    idle(1);
    check_val("race_new", 32'(obs_mdata[1:0]), 32'h1);
    idle(2);

    // Eight samples with downstream stalled in cycles 3..6.
    for (int i = 0; i < 8; i++) begin
      d27[i] = $urandom;
      if (i % 2 == 1) d27[i][7:0] = 8'h42;
    end
    sent = 0;
    pops = 0;
    for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
      step(sent < 8, d27[sent % 8], !(c >= 3 && c <= 6), 1'b0, 2'd0, 8'h00, 2'b00, acc);
      if (acc) sent++;
    end
    check_val("stall_sent", 32'(sent), 32'd8);
    check_val("stall_out", 32'(pops), 32'd8);

    // Three-neuron build: neuron index 3 is out of range and must not write.
    @(negedge clk);
    cfg_we3 = 1'b1; cfg_neuron3 = 2'd0; cfg_addr3 = 8'h1B; cfg_data3 = 2'b01;
    @(negedge clk);
    cfg_neuron3 = 2'd3; cfg_addr3 = 8'h1B; cfg_data3 = 2'b11;
    @(negedge clk);
    cfg_neuron3 = 2'd3; cfg_addr3 = 8'h00; cfg_data3 = 2'b11;
    @(negedge clk);
    cfg_we3 = 1'b0; s_valid3 = 1'b1; s_data3 = 24'h1B1B1B;
    @(negedge clk);
    s_data3 = 24'h000000;
    @(negedge clk);
    s_valid3 = 1'b0;
    #1;
    check_val("n3_valid_a", 32'(m_valid3), 32'h1);
    check_val("n3_data_a", 32'(m_data3), 32'h01);
    @(negedge clk);
    #1;
    check_val("n3_valid_b", 32'(m_valid3), 32'h1);
    check_val("n3_data_b", 32'(m_data3), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
